// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   NOP_WORD  - bubble instruction (addi x0,x0,0)
//   PC_INC    - byte increment between sequential fetches
//   state_e   - fetch-control FSM encoding (2-bit)
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam int          PC_INC   = 4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/if_hold_buf.sv
// -----------------------------------------------------------------------------
// if_hold_buf
// Single-entry {instr, pc} skid register used to park a fetched word while
// decode is stalled.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset (clears valid only)
//   load_i        - capture instr_i/pc_i and mark the entry valid
//   clear_i       - drop the entry (wins over load_i)
//   instr_i, pc_i - word and its PC to capture
//   valid_o       - entry holds a word
//   instr_o, pc_o - stored word and its PC
// -----------------------------------------------------------------------------
module if_hold_buf #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic                   valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    pc_o
);

    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, issues reads to a synchronous
// instruction memory (data one cycle after the request) and fills the IF/ID
// pipeline register. Decode stalls are absorbed by a one-entry hold buffer;
// redirects from execute flush in-flight work and restart fetch at the target.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   imem_req        - read request this cycle
//   imem_addr       - request byte address (current PC)
//   imem_rdata      - read data, valid one cycle after an accepted request
//   stall_id        - decode cannot accept; IF/ID holds
//   redirect_valid  - taken branch/jump from execute
//   redirect_pc     - redirect target (low two bits forced to zero)
//   id_valid        - IF/ID holds a real instruction
//   id_instr        - IF/ID instruction (NOP when invalid)
//   id_pc           - PC of id_instr
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = NOP_WORD
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall_id,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc
);

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   inflight_q;
    logic [PC_WIDTH-1:0]    inflight_pc_q;
    logic                   id_valid_q, id_valid_d;
    logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;
    logic [PC_WIDTH-1:0]    id_pc_q, id_pc_d;

    logic                   buf_valid;
    logic [INSTR_WIDTH-1:0] buf_instr;
    logic [PC_WIDTH-1:0]    buf_pc;
    logic                   buf_load;
    logic                   buf_clear;
    logic [PC_WIDTH-1:0]    redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & ~PC_WIDTH'(3);

    // Never request while a word is parked: the buffer must drain before any
    // new response can arrive, so buffer and response never collide.
    assign imem_req  = (state_q == S_FETCH) && !stall_id && !buf_valid && !redirect_valid;
    assign imem_addr = pc_q;

    // Park a returning word when decode is stalled; a redirect discards it.
    assign buf_load  = inflight_q && stall_id && !redirect_valid;
    assign buf_clear = redirect_valid || (!stall_id && buf_valid);

    if_hold_buf #(
        .INSTR_WIDTH(INSTR_WIDTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_hold_buf (
        .clk    (clk),
        .reset  (reset),
        .load_i (buf_load),
        .clear_i(buf_clear),
        .instr_i(imem_rdata),
        .pc_i   (inflight_pc_q),
        .valid_o(buf_valid),
        .instr_o(buf_instr),
        .pc_o   (buf_pc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: begin
                if (redirect_valid) begin
                    state_d = S_FETCH;
                end else if ((stall_id && inflight_q) || buf_valid) begin
                    state_d = S_HOLD;
                end
            end
            // Stall released: the buffer drains into IF/ID this cycle.
            S_HOLD:  if (redirect_valid || !stall_id) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    // IF/ID next value: redirect flush > stall hold > buffer > response > bubble.
    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (!stall_id) begin
            if (buf_valid) begin
                id_valid_d = 1'b1;
                id_instr_d = buf_instr;
                id_pc_d    = buf_pc;
            end else if (inflight_q) begin
                id_valid_d = 1'b1;
                id_instr_d = imem_rdata;
                id_pc_d    = inflight_pc_q;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= imem_req;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            if (redirect_valid) begin
                pc_q <= redirect_pc_aligned;
            end else if (imem_req) begin
                pc_q <= pc_q + PC_WIDTH'(PC_INC);
            end
        end
    end

    // Only meaningful while inflight_q is set.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            inflight_pc_q <= pc_q;
        end
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

endmodule
